brick_field_draw: RTL and testbench



---
 rtl/brick_field_draw.sv | 157 +++++++++++++++
 tb/tb_brick_field_draw.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_field_draw.sv
// Brick-field pixel generator: walks every brick index, fetches its health and
// rasterises each live brick one pixel per cycle in its health colour.
module brick_field_draw #(
  parameter int GRID_X   = 16,
  parameter int GRID_Y   = 4,
  parameter int BRICK_W  = 10,
  parameter int BRICK_H  = 4,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 8,
  localparam int IDXW    = $clog2(GRID_X * GRID_Y)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            go,
  output logic [IDXW-1:0] rd_addr,
  input  logic [1:0]      rd_health,
  output logic            writeEn,
  output logic [9:0]      x_out,
  output logic [9:0]      y_out,
  output logic [2:0]      colour,
  output logic            busy,
  output logic            done
);

  localparam int COLW = $clog2(GRID_X);
  localparam int PXW  = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int PYW  = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(GRID_X * GRID_Y - 1);
  localparam logic [PXW-1:0]  PX_LAST  = PXW'(BRICK_W - 1);
  localparam logic [PYW-1:0]  PY_LAST  = PYW'(BRICK_H - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    PIXEL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] idx, idx_next;
  logic [PXW-1:0]  px, px_next;
  logic [PYW-1:0]  py, py_next;
  logic [9:0]      x_next, y_next;
  logic [2:0]      colour_next;

  logic [COLW-1:0] col;
  logic [IDXW-1:0] row;
  logic [9:0]      base_x, base_y;
  logic            idx_is_last;
  logic [2:0]      health_colour;

  assign rd_addr     = idx;
  assign col         = idx[COLW-1:0];
  assign row         = idx >> COLW;
  assign base_x      = 10'(ORIGIN_X) + 10'(col) * 10'(BRICK_W);
  assign base_y      = 10'(ORIGIN_Y) + 10'(row) * 10'(BRICK_H);
  assign idx_is_last = (idx == IDX_LAST);

  always_comb begin
    case (rd_health)
      2'd3:    health_colour = 3'b100;
      2'd2:    health_colour = 3'b110;
      default: health_colour = 3'b010;
    endcase
  end

  // Pixel coordinates are computed one step ahead so x_out/y_out are
  // registered yet line up with writeEn in the same PIXEL cycle.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    px_next     = px;
    py_next     = py;
    x_next      = x_out;
    y_next      = y_out;
    colour_next = colour;
    case (state)
      IDLE: begin
        if (go) begin
          idx_next   = '0;
          state_next = FETCH;
        end
      end
      FETCH: state_next = EVAL;
      EVAL: begin
        if (rd_health == 2'd0) begin
          if (idx_is_last) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = FETCH;
          end
        end else begin
          colour_next = health_colour;
          px_next     = '0;
          py_next     = '0;
          x_next      = base_x;
          y_next      = base_y;
          state_next  = PIXEL;
        end
      end
      PIXEL: begin
        if (px == PX_LAST) begin
          px_next = '0;
          if (py == PY_LAST) begin
            py_next = '0;
            if (idx_is_last) begin
              state_next = DONE;
            end else begin
              idx_next   = idx + 1'b1;
              state_next = FETCH;
            end
          end else begin
            py_next = py + 1'b1;
            x_next  = base_x;
            y_next  = base_y + 10'(py) + 10'd1;
          end
        end else begin
          px_next = px + 1'b1;
          x_next  = base_x + 10'(px) + 10'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      px      <= '0;
      py      <= '0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      px      <= px_next;
      py      <= py_next;
      x_out   <= x_next;
      y_out   <= y_next;
      colour  <= colour_next;
      writeEn <= (state_next == PIXEL);
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_brick_field_draw.sv
// Directed bench for brick_field_draw: a registered brick memory model, a
// reference pixel list per pass and hand-computed timing/geometry checks.
module tb_brick_field_draw;

  logic       clk;
  logic       resetn;
  logic       go;
  logic [5:0] rd_addr;
  logic [1:0] rd_health;
  logic       writeEn;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  logic [1:0] mem [64];

  int checks;
  int errors;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];

  int pix_cnt, bad_pix, busy_low, done_cnt, done_c, last_c;
  int first_x, first_y, last_x, last_y, last_col;
  int post_done, post_busy, post_busy2;

  brick_field_draw dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .rd_addr   (rd_addr),
    .rd_health (rd_health),
    .writeEn   (writeEn),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read brick memory: data valid one cycle after the address.
  always_ff @(posedge clk) rd_health <= mem[rd_addr];

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int cmap(input int h);
    if (h == 3) return 4;
    if (h == 2) return 6;
    return 2;
  endfunction

  task automatic fill_mem(input int h);
    for (int i = 0; i < 64; i++) mem[i] = 2'(h);
  endtask

  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      if (mem[i] != 2'd0) begin
        for (int yy = 0; yy < 4; yy++) begin
          for (int xx = 0; xx < 10; xx++) begin
            exp_q.push_back('{x: (i % 16) * 10 + xx, y: 8 + (i / 16) * 4 + yy, c: cmap(int'(mem[i]))});
          end
        end
      end
    end
  endtask

  // One full pass: go pulse, then sample each cycle at the negedge; c=0 is FETCH of brick 0.
  task automatic applyStimulus(input int go_mid, input bit go_on_done);
    int c;
    build_model();
    pix_cnt = 0; bad_pix = 0; busy_low = 0; done_cnt = 0; done_c = -1; last_c = -1;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; last_col = -1;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    c = 0;
    while (c < 4000) begin
      if (!busy) busy_low++;
      if (writeEn) begin
        if (pix_cnt == 0) begin
          first_x = int'(x_out);
          first_y = int'(y_out);
        end
        last_x = int'(x_out);
        last_y = int'(y_out);
        last_col = int'(colour);
        last_c = c;
        if (pix_cnt >= exp_q.size()) bad_pix++;
        else if (int'(x_out) != exp_q[pix_cnt].x || int'(y_out) != exp_q[pix_cnt].y ||
                 int'(colour) != exp_q[pix_cnt].c) bad_pix++;
        pix_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_c = c;
        go = go_on_done;
        break;
      end
      go = (c == go_mid);
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    go = 1'b0;
    post_done = int'(done);
    post_busy = int'(busy);
    @(negedge clk);
    post_busy2 = int'(busy);
  endtask

  initial begin
    int c;
    int stray;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    go = 1'b0;
    fill_mem(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_writeEn", int'(writeEn), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_rd_addr", int'(rd_addr), 0);
    checkOutput("rst_x", int'(x_out), 0);
    checkOutput("rst_y", int'(y_out), 0);
    checkOutput("rst_colour", int'(colour), 0);
    resetn = 1'b1;

    // Reset in the middle of brick 5 (first pixel at c=5*42+2=212).
    fill_mem(3);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    checkOutput("fetch0_busy", int'(busy), 1);
    checkOutput("fetch0_writeEn", int'(writeEn), 0);
    for (c = 1; c <= 215; c++) @(negedge clk);
    checkOutput("b5_writeEn", int'(writeEn), 1);
    checkOutput("b5_x", int'(x_out), 53);
    checkOutput("b5_y", int'(y_out), 8);
    checkOutput("b5_rd_addr", int'(rd_addr), 5);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_writeEn", int'(writeEn), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rd_addr", int'(rd_addr), 0);
    checkOutput("abort_x", int'(x_out), 0);
    resetn = 1'b1;
    stray = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || writeEn || busy) stray++;
    end
    checkOutput("abort_quiet", stray, 0);

    // All bricks health 3.
    applyStimulus(-1, 1'b0);
    checkOutput("all3_pixels", pix_cnt, 2560);
    checkOutput("all3_order", bad_pix, 0);
    checkOutput("all3_first_x", first_x, 0);
    checkOutput("all3_first_y", first_y, 8);
    checkOutput("all3_last_col", last_col, 4);
    checkOutput("all3_done_cycle", done_c, 2688);
    checkOutput("all3_busy_low", busy_low, 0);
    checkOutput("all3_post_done", post_done, 0);
    checkOutput("all3_post_busy", post_busy, 0);

    // Only brick 17 at health 2.
    fill_mem(0);
    mem[17] = 2'd2;
    applyStimulus(-1, 1'b0);
    checkOutput("b17_pixels", pix_cnt, 40);
    checkOutput("b17_order", bad_pix, 0);
    checkOutput("b17_first_x", first_x, 10);
    checkOutput("b17_first_y", first_y, 12);
    checkOutput("b17_last_x", last_x, 19);
    checkOutput("b17_last_y", last_y, 15);
    checkOutput("b17_colour", last_col, 6);
    checkOutput("b17_done_cycle", done_c, 168);

    // Empty field.
    fill_mem(0);
    applyStimulus(-1, 1'b0);
    checkOutput("empty_pixels", pix_cnt, 0);
    checkOutput("empty_done_cycle", done_c, 128);
    checkOutput("empty_busy_low", busy_low, 0);

    // Only the last brick, health 1.
    fill_mem(0);
    mem[63] = 2'd1;
    applyStimulus(-1, 1'b0);
    checkOutput("b63_pixels", pix_cnt, 40);
    checkOutput("b63_order", bad_pix, 0);
    checkOutput("b63_last_x", last_x, 159);
    checkOutput("b63_last_y", last_y, 23);
    checkOutput("b63_colour", last_col, 2);
    checkOutput("b63_last_cycle", last_c, 167);
    checkOutput("b63_done_cycle", done_c, 168);
    checkOutput("b63_no_wrap", post_busy, 0);

    // go mid-field and coincident with done must both be ignored.
    fill_mem(0);
    mem[2] = 2'd1;
    applyStimulus(30, 1'b1);
    checkOutput("rego_pixels", pix_cnt, 40);
    checkOutput("rego_order", bad_pix, 0);
    checkOutput("rego_done_cycle", done_c, 168);
    checkOutput("rego_done_cnt", done_cnt, 1);
    checkOutput("rego_post_done", post_done, 0);
    checkOutput("rego_post_busy", post_busy, 0);
    checkOutput("rego_post_busy2", post_busy2, 0);

    // A go in IDLE afterwards starts a new pass.
    applyStimulus(-1, 1'b0);
    checkOutput("again_pixels", pix_cnt, 40);
    checkOutput("again_first_x", first_x, 20);
    checkOutput("again_first_y", first_y, 8);
    checkOutput("again_done_cycle", done_c, 168);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
